uw_motion_ctrl: RTL and testbench

Motion scheduler for the bouncing "UW" sprite renderer. It detects the start of vertical blanking from the pixel counters and divides frames down to a move rate. Once per move it sequences the X/Y position update, bounce detection, clamping and direction flips. It drives the sprite origin and the background flash colour consumed by the pixel datapath. All outputs change only during vblank, so there is no tearing.

---
 rtl/uw_motion_ctrl_pkg.sv | 73 +++++++
 rtl/uw_motion_ctrl_if.sv | 23 ++
 rtl/uw_motion_ctrl_frame_tick.sv | 49 ++++
 rtl/uw_motion_ctrl.sv | 143 ++++++++++++++
 tb/tb_uw_motion_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uw_motion_ctrl_pkg.sv
// Shared types, colours and default geometry for the UW sprite motion scheduler.
// The per-axis step/bounce rule lives here so both axes use identical arithmetic.
package uw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC_X,
        CALC_Y,
        COMMIT
    } state_e;

    localparam int unsigned H_VISIBLE_DEF    = 640;
    localparam int unsigned V_VISIBLE_DEF    = 480;
    localparam int unsigned SPRITE_W_DEF     = 93;
    localparam int unsigned SPRITE_H_DEF     = 50;
    localparam int unsigned PAD_DEF          = 50;
    localparam int unsigned STEP_DEF         = 2;
    localparam int unsigned FRAME_DIV_DEF    = 2;
    localparam int unsigned FLASH_FRAMES_DEF = 8;

    localparam logic [5:0] BG_IDLE      = 6'b000001;
    localparam logic [5:0] CORNER_COLOR = 6'b111111;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
        logic       hit;
    } axis_t;

    function automatic logic [5:0] palette(input logic [1:0] idx);
        logic [5:0] c;
        unique case (idx)
            2'd0:    c = 6'b110011;
            2'd1:    c = 6'b001111;
            2'd2:    c = 6'b111100;
            default: c = 6'b100110;
        endcase
        return c;
    endfunction

    // 11-bit arithmetic; landing exactly on a limit counts as a hit.
    function automatic axis_t axis_step(input logic [9:0]  pos,
                                        input logic        dir,
                                        input logic [10:0] lo,
                                        input logic [10:0] hi,
                                        input logic [10:0] step);
        axis_t       r;
        logic [10:0] p;
        logic [10:0] nxt;
        p     = {1'b0, pos};
        nxt   = p + step;
        r.pos = pos;
        r.dir = dir;
        r.hit = 1'b0;
        if (dir) begin
            if (nxt >= hi) begin
                r.pos = 10'(hi);
                r.dir = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = 10'(nxt);
            end
        end else if (p <= lo + step) begin
            r.pos = 10'(lo);
            r.dir = 1'b1;
            r.hit = 1'b1;
        end else begin
            r.pos = 10'(p - step);
        end
        return r;
    endfunction

endpackage

// File: rtl/uw_motion_ctrl_if.sv
// Pixel-counter inputs and sprite/background outputs of the motion scheduler.
interface uw_motion_ctrl_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pause;
    logic [9:0] obj_x;
    logic [9:0] obj_y;
    logic       dir_right;
    logic       dir_down;
    logic [5:0] bg_color;
    logic       frame_tick;
    logic       bounce;

    modport master (
        output pix_x, pix_y, pause,
        input  obj_x, obj_y, dir_right, dir_down, bg_color, frame_tick, bounce
    );

    modport slave (
        input  pix_x, pix_y, pause,
        output obj_x, obj_y, dir_right, dir_down, bg_color, frame_tick, bounce
    );
endinterface

// File: rtl/uw_motion_ctrl_frame_tick.sv
// Start-of-vblank detect and frame divider: one frame_tick per vblank entry,
// move_en on the tick that completes a FRAME_DIV group while not paused.
module uw_frame_tick #(
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned FRAME_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pix_x_i,
    input  logic [9:0] pix_y_i,
    input  logic       pause_i,
    output logic       sof_rise_o,
    output logic       frame_tick_o,
    output logic       move_en_o
);
    localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

    logic          sof;
    logic          sof_q;
    logic          tick_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    assign sof        = (pix_x_i == '0) && (pix_y_i == 10'(V_VISIBLE));
    assign sof_rise_o = sof & ~sof_q;

    always_comb begin
        div_d = div_q;
        if (tick_q) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof_q  <= 1'b0;
            tick_q <= 1'b0;
            div_q  <= '0;
        end else begin
            sof_q  <= sof;
            tick_q <= sof_rise_o;
            div_q  <= div_d;
        end
    end

    assign frame_tick_o = tick_q;
    assign move_en_o    = tick_q && (div_q == DIV_LAST) && !pause_i;
endmodule

// File: rtl/uw_motion_ctrl.sv
// Bouncing-sprite motion scheduler: once per move it steps X, then Y, then
// commits position, direction, bounce pulse and flash colour during vblank.
module uw_motion_ctrl
    import uw_pkg::*;
#(
    parameter int unsigned H_VISIBLE    = H_VISIBLE_DEF,
    parameter int unsigned V_VISIBLE    = V_VISIBLE_DEF,
    parameter int unsigned SPRITE_W     = SPRITE_W_DEF,
    parameter int unsigned SPRITE_H     = SPRITE_H_DEF,
    parameter int unsigned PAD          = PAD_DEF,
    parameter int unsigned STEP         = STEP_DEF,
    parameter int unsigned FRAME_DIV    = FRAME_DIV_DEF,
    parameter int unsigned FLASH_FRAMES = FLASH_FRAMES_DEF
) (
    input logic             clk,
    input logic             rst,
    uw_motion_ctrl_if.slave mc
);
    localparam logic [10:0] XMAX = 11'(H_VISIBLE - PAD - SPRITE_W);
    localparam logic [10:0] YMAX = 11'(V_VISIBLE - PAD - SPRITE_H);
    localparam logic [10:0] LO   = 11'(PAD);
    localparam logic [10:0] STP  = 11'(STEP);
    localparam int unsigned FW   = $clog2(2 * FLASH_FRAMES + 1);

    state_e        state_q, state_d;
    logic          sof_rise, frame_tick, move_en;
    logic          ld_x, ld_y, commit;
    axis_t         nx_q, ny_q;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          dr_q, dr_d, dd_q, dd_d;
    logic [5:0]    color_q, color_d;
    logic [1:0]    pal_q, pal_d;
    logic [FW-1:0] flash_q, flash_d;
    logic          bounce_q, bounce_d;

    uw_frame_tick #(
        .V_VISIBLE (V_VISIBLE),
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick (
        .clk          (clk),
        .rst          (rst),
        .pix_x_i      (mc.pix_x),
        .pix_y_i      (mc.pix_y),
        .pause_i      (mc.pause),
        .sof_rise_o   (sof_rise),
        .frame_tick_o (frame_tick),
        .move_en_o    (move_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A vblank edge seen while busy is only counted by the divider.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sof_rise) state_d = CALC_X;
            CALC_X:  state_d = move_en ? CALC_Y : IDLE;
            CALC_Y:  state_d = COMMIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_x   = (state_q == CALC_X) && move_en;
        ld_y   = (state_q == CALC_Y);
        commit = (state_q == COMMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nx_q <= '0;
            ny_q <= '0;
        end else begin
            if (ld_x) nx_q <= axis_step(x_q, dr_q, LO, XMAX, STP);
            if (ld_y) ny_q <= axis_step(y_q, dd_q, LO, YMAX, STP);
        end
    end

    // The flash countdown runs every frame; a commit in the same cycle wins.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dr_d     = dr_q;
        dd_d     = dd_q;
        color_d  = color_q;
        pal_d    = pal_q;
        flash_d  = flash_q;
        bounce_d = 1'b0;
        if (frame_tick && (flash_q != '0)) begin
            flash_d = flash_q - 1'b1;
            if (flash_q == FW'(1)) color_d = BG_IDLE;
        end
        if (commit) begin
            x_d  = nx_q.pos;
            y_d  = ny_q.pos;
            dr_d = nx_q.dir;
            dd_d = ny_q.dir;
            if (nx_q.hit && ny_q.hit) begin
                color_d  = CORNER_COLOR;
                flash_d  = FW'(2 * FLASH_FRAMES);
                bounce_d = 1'b1;
            end else if (nx_q.hit || ny_q.hit) begin
                pal_d    = pal_q + 2'd1;
                color_d  = palette(pal_q + 2'd1);
                flash_d  = FW'(FLASH_FRAMES);
                bounce_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= 10'(PAD);
            y_q      <= 10'(PAD);
            dr_q     <= 1'b1;
            dd_q     <= 1'b1;
            color_q  <= BG_IDLE;
            pal_q    <= '0;
            flash_q  <= '0;
            bounce_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            dr_q     <= dr_d;
            dd_q     <= dd_d;
            color_q  <= color_d;
            pal_q    <= pal_d;
            flash_q  <= flash_d;
            bounce_q <= bounce_d;
        end
    end

    assign mc.obj_x      = x_q;
    assign mc.obj_y      = y_q;
    assign mc.dir_right  = dr_q;
    assign mc.dir_down   = dd_q;
    assign mc.bg_color   = color_q;
    assign mc.frame_tick = frame_tick;
    assign mc.bounce     = bounce_q;
endmodule

// File: tb/tb_uw_motion_ctrl.sv
// Randomised frame-level bench for uw_motion_ctrl against a per-frame motion model,
// using a default-geometry instance and a small-screen instance for corner hits.
module tb_uw_motion_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uw_motion_ctrl_if a_if ();
    uw_motion_ctrl_if b_if ();

    uw_motion_ctrl dut_a (
        .clk (clk),
        .rst (rst),
        .mc  (a_if.slave)
    );

    uw_motion_ctrl #(
        .H_VISIBLE (200),
        .V_VISIBLE (200),
        .SPRITE_W  (50),
        .SPRITE_H  (50),
        .PAD       (10)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .mc  (b_if.slave)
    );

    int checks = 0;
    int errors = 0;
    bit sel = 1'b0;

    logic [9:0] o_x, o_y;
    logic       o_dr, o_dd, o_tick, o_bnc;
    logic [5:0] o_bg;
    assign o_x    = sel ? b_if.obj_x      : a_if.obj_x;
    assign o_y    = sel ? b_if.obj_y      : a_if.obj_y;
    assign o_dr   = sel ? b_if.dir_right  : a_if.dir_right;
    assign o_dd   = sel ? b_if.dir_down   : a_if.dir_down;
    assign o_bg   = sel ? b_if.bg_color   : a_if.bg_color;
    assign o_tick = sel ? b_if.frame_tick : a_if.frame_tick;
    assign o_bnc  = sel ? b_if.bounce     : a_if.bounce;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: state as it stands after each frame.
    int g_h, g_v, g_lo, g_xmax, g_ymax;
    int m_x, m_y, m_dr, m_dd, m_pal, m_flash, m_bg, m_frames, m_moves, m_bnc;
    int pal_tab [4] = '{51, 15, 60, 38};
    int last_bnc;

    task automatic model_reset(input int h, input int v, input int sw, input int sh, input int pad);
        g_h = h; g_v = v; g_lo = pad;
        g_xmax = h - pad - sw;
        g_ymax = v - pad - sh;
        m_x = pad; m_y = pad; m_dr = 1; m_dd = 1;
        m_pal = 0; m_flash = 0; m_bg = 1;
        m_frames = 0; m_moves = 0; m_bnc = 0;
    endtask

    task automatic step_axis(inout int pos, inout int dir, input int hi, output int hit);
        hit = 0;
        if (dir == 1) begin
            pos = pos + 2;
            if (pos >= hi) begin pos = hi; dir = 0; hit = 1; end
        end else begin
            pos = pos - 2;
            if (pos <= g_lo) begin pos = g_lo; dir = 1; hit = 1; end
        end
    endtask

    task automatic model_frame(input bit p);
        int hx, hy;
        m_bnc = 0;
        if (m_flash > 0) begin
            m_flash--;
            if (m_flash == 0) m_bg = 1;
        end
        if ((m_frames % 2) == 1 && !p) begin
            m_moves++;
            step_axis(m_x, m_dr, g_xmax, hx);
            step_axis(m_y, m_dd, g_ymax, hy);
            if (hx != 0 && hy != 0) begin
                m_bg = 63; m_flash = 16; m_bnc = 1;
            end else if (hx != 0 || hy != 0) begin
                m_pal = (m_pal + 1) % 4;
                m_bg = pal_tab[m_pal]; m_flash = 8; m_bnc = 1;
            end
        end
        m_frames++;
    endtask

    task automatic set_pix(input bit sof);
        int px, py;
        if (sof) begin
            px = 0; py = g_v;
        end else begin
            py = ($urandom_range(3, 0) == 0) ? g_v : int'($urandom_range(g_v - 1, 0));
            px = (py == g_v) ? int'($urandom_range(g_h - 1, 1)) : int'($urandom_range(g_h - 1, 0));
        end
        if (sel) begin b_if.pix_x = 10'(px); b_if.pix_y = 10'(py); end
        else     begin a_if.pix_x = 10'(px); a_if.pix_y = 10'(py); end
    endtask

    task automatic set_pause(input bit p);
        if (sel) b_if.pause = p;
        else     a_if.pause = p;
    endtask

    // One frame: sof held for 'hold' cycles, then a random gap; pause is
    // scrambled mid-sequence to show it is only sampled at the tick.
    task automatic run_frame(input bit p, input int hold);
        int gap, ox, oy, odr, odd;
        gap = $urandom_range(8, 5);
        ox = m_x; oy = m_y; odr = m_dr; odd = m_dd;
        @(negedge clk);
        set_pause(p);
        set_pix(1'b1);
        for (int t = 1; t <= hold + gap; t++) begin
            @(negedge clk);
            if (t == 1) begin
                check("frame_tick", o_tick, 1);
                model_frame(p);
            end else if (t <= 6) begin
                check("tick_once", o_tick, 0);
            end
            if (t == 3) begin
                check("x_before_commit", o_x, ox);
                check("y_before_commit", o_y, oy);
                check("dirs_before_commit", o_dr * 2 + o_dd, odr * 2 + odd);
                check("bounce_early", o_bnc, 0);
            end
            if (t == 4) begin
                check("obj_x", o_x, m_x);
                check("obj_y", o_y, m_y);
                check("dir_right", o_dr, m_dr);
                check("dir_down", o_dd, m_dd);
                check("bg_color", o_bg, m_bg);
                check("bounce", o_bnc, m_bnc);
                last_bnc = o_bnc;
            end
            if (t == 5) check("bounce_width", o_bnc, 0);
            if (t == 2) set_pause(1'($urandom_range(1, 0)));
            set_pix(t < hold);
        end
    endtask

    function automatic bit rnd_pause();
        return ($urandom_range(7, 0) == 0);
    endfunction

    initial begin
        int sx, sy;
        rst = 1'b1;
        a_if.pix_x = 10'd1; a_if.pix_y = 10'd1; a_if.pause = 1'b0;
        b_if.pix_x = 10'd1; b_if.pix_y = 10'd1; b_if.pause = 1'b0;
        last_bnc = 0;
        model_reset(640, 480, 93, 50, 50);
        repeat (3) @(negedge clk);
        check("rst_x", o_x, 50);
        check("rst_y", o_y, 50);
        check("rst_dirs", o_dr * 2 + o_dd, 3);
        check("rst_bg", o_bg, 1);
        check("rst_tick", o_tick, 0);
        check("rst_bounce", o_bnc, 0);
        rst = 1'b0;

        run_frame(1'b0, 1);
        run_frame(1'b0, 5);
        check("two_frames_x", o_x, 52);
        check("two_frames_y", o_y, 52);
        check("two_frames_bg", o_bg, 1);
        check("two_frames_bounce", last_bnc, 0);

        while (m_moves < 165) run_frame(rnd_pause(), $urandom_range(4, 1));
        check("bottom_y", o_y, 380);
        check("bottom_dir_down", o_dd, 0);
        check("bottom_bounce", last_bnc, 1);
        check("bottom_bg", o_bg, 15);
        repeat (7) run_frame(rnd_pause(), $urandom_range(4, 1));
        check("flash_held", o_bg, 15);
        run_frame(rnd_pause(), $urandom_range(4, 1));
        check("flash_expired", o_bg, 1);

        while (m_moves < 224) run_frame(rnd_pause(), $urandom_range(4, 1));
        check("right_x_clamped", o_x, 497);
        check("right_dir", o_dr, 0);
        check("right_bg", o_bg, 60);

        sx = m_x; sy = m_y;
        repeat (10) run_frame(1'b1, $urandom_range(4, 1));
        check("paused_x", o_x, sx);
        check("paused_y", o_y, sy);

        if ((m_frames % 2) == 0) run_frame(1'b1, 1);
        @(negedge clk);
        a_if.pause = 1'b0;
        set_pix(1'b1);
        repeat (3) begin
            @(negedge clk);
            set_pix(1'b0);
        end
        rst = 1'b1;
        #1;
        check("rst_commit_x", o_x, 50);
        check("rst_commit_y", o_y, 50);
        check("rst_commit_dirs", o_dr * 2 + o_dd, 3);
        check("rst_commit_tick", o_tick, 0);
        check("rst_commit_bounce", o_bnc, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset(640, 480, 93, 50, 50);
        repeat (4) run_frame(1'b0, $urandom_range(4, 1));
        check("after_rst_x", o_x, 54);

        sel = 1'b1;
        model_reset(200, 200, 50, 50, 10);
        while (m_moves < 65) run_frame(1'b0, $urandom_range(4, 1));
        check("corner_x", o_x, 140);
        check("corner_y", o_y, 140);
        check("corner_dirs", o_dr * 2 + o_dd, 0);
        check("corner_bg", o_bg, 63);
        check("corner_bounce", last_bnc, 1);
        repeat (15) run_frame(rnd_pause(), $urandom_range(4, 1));
        check("corner_flash_held", o_bg, 63);
        run_frame(rnd_pause(), $urandom_range(4, 1));
        check("corner_flash_expired", o_bg, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
